// File: rtl/perceptron_multiclass.sv
// rtl/perceptron_multiclass.sv - multiclass binary-image perceptron with bit-serial MAC and sequential argmax
module perceptron_multiclass #(
  parameter int WIDTH   = 25,
  parameter int CLASSES = 4,
  parameter int W_BITS  = 8,
  parameter int THRESH  = 0,
  localparam int CW     = $clog2(CLASSES),
  localparam int IW     = $clog2(WIDTH),
  localparam int ACC_W  = W_BITS + $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             wr_en,
  input  logic [CW-1:0]    wr_class,
  input  logic [IW-1:0]    wr_idx,
  input  logic [W_BITS-1:0] wr_data,
  output logic [CW-1:0]    out_class,
  output logic             out_none,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic signed [ACC_W-1:0] THR = ACC_W'(THRESH);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_ARG, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         in_q, in_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [CW-1:0]            cls_q, cls_d;
  logic signed [ACC_W-1:0]  acc_q [CLASSES];
  logic signed [ACC_W-1:0]  acc_d [CLASSES];
  logic signed [ACC_W-1:0]  best_acc_q, best_acc_d;
  logic [CW-1:0]            best_idx_q, best_idx_d;
  logic                     none_q, none_d;
  logic signed [W_BITS-1:0] w_q [CLASSES][WIDTH];
  logic                     wr_hit;

  assign wr_hit = (state_q == S_IDLE) && wr_en &&
                  (32'(wr_class) < CLASSES) && (32'(wr_idx) < WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_d       = in_q;
    idx_d      = idx_q;
    cls_d      = cls_q;
    acc_d      = acc_q;
    best_acc_d = best_acc_q;
    best_idx_d = best_idx_q;
    none_d     = none_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_d  = in;
          idx_d = '0;
          for (int c = 0; c < CLASSES; c++) acc_d[c] = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        for (int c = 0; c < CLASSES; c++) begin
          if (in_q[idx_q])
            acc_d[c] = acc_q[c] + {{(ACC_W-W_BITS){w_q[c][idx_q][W_BITS-1]}}, w_q[c][idx_q]};
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(WIDTH - 1)) begin
          cls_d   = '0;
          state_d = S_ARG;
        end
      end
      S_ARG: begin
        // class 0 seeds the running best; later classes need strictly greater to win ties
        if (cls_q == '0 || acc_q[cls_q] > best_acc_q) begin
          best_acc_d = acc_q[cls_q];
          best_idx_d = cls_q;
        end
        cls_d = cls_q + CW'(1);
        if (cls_q == CW'(CLASSES - 1)) begin
          none_d  = (best_acc_d <= THR);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q       <= '0;
      idx_q      <= '0;
      cls_q      <= '0;
      best_acc_q <= '0;
      best_idx_q <= '0;
      none_q     <= 1'b0;
      for (int c = 0; c < CLASSES; c++) begin
        acc_q[c] <= '0;
        for (int i = 0; i < WIDTH; i++) w_q[c][i] <= '0;
      end
    end else begin
      in_q       <= in_d;
      idx_q      <= idx_d;
      cls_q      <= cls_d;
      best_acc_q <= best_acc_d;
      best_idx_q <= best_idx_d;
      none_q     <= none_d;
      for (int c = 0; c < CLASSES; c++) acc_q[c] <= acc_d[c];
      if (wr_hit) w_q[wr_class][wr_idx] <= wr_data;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_class = best_idx_q;
  assign out_acc   = best_acc_q;
  assign out_none  = none_q;

endmodule

// File: tb/tb_perceptron_multiclass.sv
// tb/tb_perceptron_multiclass.sv - scoreboard bench for perceptron_multiclass
module tb_perceptron_multiclass;
  localparam int WIDTH = 25, CLASSES = 4, W_BITS = 8;
  localparam int CW = 2, IW = 5, ACC_W = 13;
  localparam int LAT_T = (WIDTH + CLASSES) * 10 + 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [WIDTH-1:0] in = '0;
  logic in_valid = 1'b0, in_ready, wr_en = 1'b0, out_none, out_valid, out_ready = 1'b1, busy;
  logic [CW-1:0] wr_class = '0, out_class;
  logic [IW-1:0] wr_idx = '0;
  logic [W_BITS-1:0] wr_data = '0;
  logic [ACC_W-1:0] out_acc;

  perceptron_multiclass #(.WIDTH(WIDTH), .CLASSES(CLASSES), .W_BITS(W_BITS), .THRESH(0)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_class(wr_class), .wr_idx(wr_idx), .wr_data(wr_data),
    .out_class(out_class), .out_none(out_none), .out_acc(out_acc),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { int cls; int none; int acc; time t_hs; string name; } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) prev_valid = 1'b0;
    else begin
      if (out_valid && !prev_valid) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_result: got out_valid=1 expected no result");
        end else chk({q[0].name, "_latency"}, int'($time - q[0].t_hs), LAT_T);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_class"}, int'(out_class), e.cls);
        chk({e.name, "_acc"}, int'($signed(out_acc)), e.acc);
        chk({e.name, "_none"}, int'(out_none), e.none);
      end
      prev_valid = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int c, input int i, input int d);
    wr_en = 1'b1; wr_class = CW'(c); wr_idx = IW'(i); wr_data = W_BITS'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic frame(input logic [WIDTH-1:0] img, input bit expect_res,
                       input int cls, input int none, input int acc, input string name);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (!in_ready) chk({name, "_in_ready_timeout"}, 0, 1);
    in = img; in_valid = 1'b1;
    @(posedge clk);
    if (expect_res) begin
      e.cls = cls; e.none = none; e.acc = acc; e.t_hs = $time; e.name = name;
      q.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 200) begin tick(); n++; end
    chk({name, "_drain"}, q.size(), 0);
    tick();
  endtask

  initial begin
    int n;
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_class", int'(out_class), 0);
    chk("rst_out_none", int'(out_none), 0);
    chk("rst_out_acc", int'(out_acc), 0);
    tick(); rst_n = 1'b1; tick();

    // 1: abort mid-ACC, weights must come back zero
    wr(0, 0, 50);
    frame(25'h1FFFFFF, 1'b0, 0, 0, 0, "abort");
    repeat (5) tick();
    chk("abort_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    tick(); rst_n = 1'b1;
    repeat (40) tick();

    // 2: w[2][0..3]=+2
    for (int i = 0; i < 4; i++) wr(2, i, 2);
    frame(25'h000000F, 1'b1, 2, 0, 8, "basic");
    drain("basic");

    // 3: all weights zero
    for (int i = 0; i < 4; i++) wr(2, i, 0);
    frame(25'h1FFFFFF, 1'b1, 0, 1, 0, "zero");
    drain("zero");

    // 4: tie between classes 1 and 3
    wr(1, 5, 5); wr(3, 5, 5);
    frame(25'h0000020, 1'b1, 1, 0, 5, "tie");
    drain("tie");

    // 5: all weights -128
    for (int c = 0; c < CLASSES; c++)
      for (int i = 0; i < WIDTH; i++) wr(c, i, -128);
    frame(25'h1FFFFFF, 1'b1, 0, 1, -3200, "neg");
    drain("neg");

    // 6: back-pressure with ignored writes while busy
    wr(3, 10, 100);
    out_ready = 1'b0;
    frame(25'h0000400, 1'b1, 3, 0, 100, "bp");
    wr(3, 10, 1); wr(0, 10, 127);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("bp_valid_seen", int'(out_valid), 1);
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1; wr_class = 2'd3; wr_idx = 5'd10; wr_data = 8'd0;
      tick();
      chk("bp_hold", int'({out_valid, in_ready, busy, out_none, out_class}) * 65536 + int'(out_acc),
          int'({1'b1, 1'b0, 1'b1, 1'b0, 2'd3}) * 65536 + 100);
    end
    wr_en = 1'b0;
    out_ready = 1'b1;
    drain("bp");
    frame(25'h0000400, 1'b1, 3, 0, 100, "rerun");
    drain("rerun");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
